load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  RV32I load/store unit between the execute stage of the core and the
//  data memory. Takes one request per transaction (LB/LH/LW/LBU/LHU, SB/SH/SW),
//  drives the word-addressed memory port with byte enables, and returns
//  sign- or zero-extended load data. Misaligned accesses become two word accesses.
// PARAMETERS
//  ADDR_W   10  word-address width of the data memory (depth 2**ADDR_W words)
// PORTS
//  clk        in   1       clock, all state changes on the rising edge
//  rst_n      in   1       synchronous active-low reset
//  req_valid  in   1       core request valid
//  req_ready  out  1       unit can accept a request (high only in IDLE)
//  req_we     in   1       1 = store, 0 = load
//  req_funct3 in   3       RV32I funct3 of the load/store instruction
//  req_addr   in   32      byte address
//  req_wdata  in   32      store data (rs2)
//  rsp_valid  out  1       one-cycle pulse: transaction complete
//  rsp_rdata  out  32      extended load data (0 for stores and errors)
//  rsp_err    out  1       illegal funct3; qualified by rsp_valid
//  mem_en     out  1       memory access strobe
//  mem_we     out  4       byte write enables (0 = read)
//  mem_addr   out  ADDR_W  word address
//  mem_wdata  out  32      lane-aligned write data
//  mem_rdata  in   32      read data, valid the cycle after mem_en with mem_we=0
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state IDLE, req_ready=1, rsp_valid=0, rsp_err=0,
//    rsp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Reset mid-transaction
//    abandons it: no further mem_en, no rsp_valid. Core holds req_valid=0 in reset.
//  - Handshake: accept on req_valid & req_ready edge; request fields latched;
//    req_ready low until the edge after rsp_valid. mem_* are driven only from
//    registered state (no combinational path req_* -> mem_*).
//  - off = addr[1:0]; w0 = addr[ADDR_W+1:2]; w1 = w0+1 mod 2**ADDR_W (wraps);
//    addr[31:ADDR_W+2] ignored. split = (W & off!=0) | (H & off==3).
//  - Legal funct3: load 0,1,2,4,5; store 0,1,2. Otherwise -> RESP directly,
//    rsp_err=1, no memory access.
//  - FSM: IDLE -> MEM0 -> [load: DATA0] -> (split ? MEM1 -> [load: DATA1]) -> RESP -> IDLE.
//    MEM0/MEM1: mem_en=1, mem_addr=w0/w1. DATA0/DATA1: capture mem_rdata.
//    RESP: rsp_valid=1 for exactly one cycle; rsp_rdata/rsp_err held until next RESP.
//  - Latency from accept edge T0 to rsp_valid: aligned store T2, split store T3,
//    aligned load T3, split load T5, illegal T1.
//  - Store: be = {B:1,H:3,W:F} (4-bit); {hi,lo}_be = be<<off (8 bits),
//    {hi,lo}_data = wdata<<(8*off) (64 bits); MEM0 uses lo, MEM1 uses hi.
//  - Load: v = {d1,d0} >> (8*off) (d1=0 if no split); LB sext v[7:0], LBU zext
//    v[7:0], LH sext v[15:0], LHU zext v[15:0], LW v[31:0].
//  - Unused lanes of mem_wdata are don't-care but driven to 0; mem_we=0 on loads.
// TESTING
//  1 SW addr 0x8 wdata 0xDEADBEEF -> T1 mem_en=1 mem_addr=2 mem_we=F wdata=DEADBEEF;
//    T2 rsp_valid=1 rsp_err=0; memory word2 = DEADBEEF.
//  2 word0=0x80FF7F01: LB 0x3 -> FFFFFF80; LBU 0x3 -> 00000080; LH 0x2 -> FFFF80FF;
//    LHU 0x0 -> 00007F01; each rsp_valid at T3.
//  3 word0=0x44332211 word1=0x88776655, LW 0x1 -> mem_addr 0 at T1, 1 at T3,
//    rsp_rdata=0x55443322 at T5; LW 0xFFD (ADDR_W=10) -> mem_addr 1023 then 0.
//  4 SH 0x7 wdata 0x0000ABCD -> T1 addr1 we=1000 wdata[31:24]=CD; T2 addr2 we=0001
//    wdata[7:0]=AB; T3 rsp_valid; other bytes of words 1,2 unchanged.
//  5 load funct3=3 (and store funct3=4) -> rsp_valid=1 rsp_err=1 rsp_rdata=0 at T1,
//    mem_en never high; next legal request accepted at T2.
//  6 rst_n=0 at T1 of SW 0x2 (split) -> no mem_en at T2, no rsp_valid; req_ready=1 and
//    outputs at reset values after the edge; word1 unchanged.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-request and data-memory signal bundle for the RV32I load/store unit.
// The slave modport is the unit itself. The master modport is its environment (core and memory).
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW request
// into one or two word accesses with byte enables and returns extended load data.
module load_store_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  load_store_unit_if.slave     lsu
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM0, S_DATA0, S_MEM1, S_DATA1, S_RESP
  } state_t;

  state_t            r_state, w_nxt_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_w0;
  logic [31:0]       r_wdata;
  logic [31:0]       r_d0;

  logic              r_req_ready, r_rsp_valid, r_rsp_err, r_mem_en;
  logic [31:0]       r_rsp_rdata, r_mem_wdata;
  logic [3:0]        r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;

  logic              w_nxt_rsp_valid, w_nxt_rsp_err, w_nxt_mem_en;
  logic [31:0]       w_nxt_rsp_rdata, w_nxt_mem_wdata;
  logic [3:0]        w_nxt_mem_we;
  logic [ADDR_W-1:0] w_nxt_mem_addr;

  logic              w_req_legal, w_split;
  logic [ADDR_W-1:0] w_w1;
  logic [31:0]       w_load_data;
  logic              w_unused_addr;

  function automatic logic f_legal(input logic we, input logic [2:0] f3);
    if (we) f_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    f_legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                      (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  // An access crosses a word boundary when its last byte lands in the next word.
  function automatic logic f_split(input logic [2:0] f3, input logic [1:0] off);
    f_split = ((f3[1:0] == 2'd2) && (off != 2'd0)) ||
              ((f3[1:0] == 2'd1) && (off == 2'd3));
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    f_be = 4'b0001;
      2'd1:    f_be = 4'b0011;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] f_be_lo(input logic [2:0] f3, input logic [1:0] off);
    f_be_lo = 4'(f_be(f3) << off);
  endfunction

  function automatic logic [3:0] f_be_hi(input logic [2:0] f3, input logic [1:0] off);
    f_be_hi = 4'(({4'b0, f_be(f3)} << off) >> 4);
  endfunction

  function automatic logic [31:0] f_lane_lo(input logic [31:0] wd, input logic [1:0] off);
    f_lane_lo = 32'(wd << {off, 3'b000});
  endfunction

  function automatic logic [31:0] f_lane_hi(input logic [31:0] wd, input logic [1:0] off);
    f_lane_hi = 32'(({32'b0, wd} << {off, 3'b000}) >> 32);
  endfunction

  function automatic logic [31:0] f_ext(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] d1, input logic [31:0] d0);
    logic [31:0] v;
    v = 32'({d1, d0} >> {off, 3'b000});
    case (f3)
      3'd0:    f_ext = {{24{v[7]}}, v[7:0]};
      3'd1:    f_ext = {{16{v[15]}}, v[15:0]};
      3'd4:    f_ext = {24'b0, v[7:0]};
      3'd5:    f_ext = {16'b0, v[15:0]};
      default: f_ext = v;
    endcase
  endfunction

  assign w_req_legal   = f_legal(lsu.req_we, lsu.req_funct3);
  assign w_split       = f_split(r_funct3, r_off);
  assign w_w1          = ADDR_W'(r_w0 + ADDR_W'(1));
  assign w_unused_addr = ^lsu.req_addr[31:ADDR_W+2];

  // Aligned loads finish from DATA0 with the live read word; split loads combine both words.
  assign w_load_data = f_ext(r_funct3, r_off,
                             (r_state == S_DATA1) ? lsu.mem_rdata : 32'h0,
                             (r_state == S_DATA0) ? lsu.mem_rdata : r_d0);

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_mem_en    = 1'b0;
    w_nxt_mem_we    = 4'h0;
    w_nxt_mem_addr  = '0;
    w_nxt_mem_wdata = 32'h0;
    w_nxt_rsp_valid = 1'b0;
    w_nxt_rsp_rdata = r_rsp_rdata;
    w_nxt_rsp_err   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (lsu.req_valid) begin
          if (!w_req_legal) begin
            w_nxt_state     = S_RESP;
            w_nxt_rsp_valid = 1'b1;
            w_nxt_rsp_err   = 1'b1;
            w_nxt_rsp_rdata = 32'h0;
          end else begin
            w_nxt_state    = S_MEM0;
            w_nxt_mem_en   = 1'b1;
            w_nxt_mem_addr = lsu.req_addr[ADDR_W+1:2];
            if (lsu.req_we) begin
              w_nxt_mem_we    = f_be_lo(lsu.req_funct3, lsu.req_addr[1:0]);
              w_nxt_mem_wdata = f_lane_lo(lsu.req_wdata, lsu.req_addr[1:0]);
            end
          end
        end
      end
      S_MEM0: begin
        if (!r_we) begin
          w_nxt_state = S_DATA0;
        end else if (w_split) begin
          w_nxt_state     = S_MEM1;
          w_nxt_mem_en    = 1'b1;
          w_nxt_mem_addr  = w_w1;
          w_nxt_mem_we    = f_be_hi(r_funct3, r_off);
          w_nxt_mem_wdata = f_lane_hi(r_wdata, r_off);
        end else begin
          w_nxt_state     = S_RESP;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_err   = 1'b0;
          w_nxt_rsp_rdata = 32'h0;
        end
      end
      S_DATA0: begin
        if (w_split) begin
          w_nxt_state    = S_MEM1;
          w_nxt_mem_en   = 1'b1;
          w_nxt_mem_addr = w_w1;
        end else begin
          w_nxt_state     = S_RESP;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_err   = 1'b0;
          w_nxt_rsp_rdata = w_load_data;
        end
      end
      S_MEM1: begin
        if (r_we) begin
          w_nxt_state     = S_RESP;
          w_nxt_rsp_valid = 1'b1;
          w_nxt_rsp_err   = 1'b0;
          w_nxt_rsp_rdata = 32'h0;
        end else begin
          w_nxt_state = S_DATA1;
        end
      end
      S_DATA1: begin
        w_nxt_state     = S_RESP;
        w_nxt_rsp_valid = 1'b1;
        w_nxt_rsp_err   = 1'b0;
        w_nxt_rsp_rdata = w_load_data;
      end
      S_RESP:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 4'h0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_w0        <= '0;
      r_wdata     <= 32'h0;
      r_d0        <= 32'h0;
    end else begin
      r_state     <= w_nxt_state;
      r_req_ready <= (w_nxt_state == S_IDLE);
      r_rsp_valid <= w_nxt_rsp_valid;
      r_rsp_rdata <= w_nxt_rsp_rdata;
      r_rsp_err   <= w_nxt_rsp_err;
      r_mem_en    <= w_nxt_mem_en;
      r_mem_we    <= w_nxt_mem_we;
      r_mem_addr  <= w_nxt_mem_addr;
      r_mem_wdata <= w_nxt_mem_wdata;
      if ((r_state == S_IDLE) && lsu.req_valid) begin
        r_we     <= lsu.req_we;
        r_funct3 <= lsu.req_funct3;
        r_off    <= lsu.req_addr[1:0];
        r_w0     <= lsu.req_addr[ADDR_W+1:2];
        r_wdata  <= lsu.req_wdata;
      end
      if (r_state == S_DATA0) r_d0 <= lsu.mem_rdata;
    end
  end

  assign lsu.req_ready = r_req_ready;
  assign lsu.rsp_valid = r_rsp_valid;
  assign lsu.rsp_rdata = r_rsp_rdata;
  assign lsu.rsp_err   = r_rsp_err;
  assign lsu.mem_en    = r_mem_en;
  assign lsu.mem_we    = r_mem_we;
  assign lsu.mem_addr  = r_mem_addr;
  assign lsu.mem_wdata = r_mem_wdata;

endmodule
